// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing, data width and the frame state
// names used by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned BIT_CYCLES_DEF = 868;
    localparam int unsigned DATA_BITS      = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO in front of the UART transmitter.
// Storage is registered; the head entry is presented show-ahead on o_pop_data.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = DATA_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;

endmodule

// File: rtl/uart_send.sv
// UART transmitter: FIFO-buffered bytes serialised as 8N1, LSB first.
// Define UART_PARITY_EN to insert an even-parity bit between data and stop.
module uart_send
    import uart_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = BIT_CYCLES_DEF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dout_vld,
    input  logic [DATA_BITS-1:0] dout_data,
    output logic                 dout_rdy,
    output logic                 dout,
    output logic                 busy
);

    localparam int unsigned DW = $clog2(BIT_CYCLES);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    uart_state_t          r_state;
    uart_state_t          w_state_nxt;
    logic [DW-1:0]        r_div_cnt;
    logic [2:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_dout;
    logic                 w_dout_nxt;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_bit_end;
    logic                 w_last_bit;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [CW-1:0]        w_fifo_count;
    logic [DATA_BITS-1:0] w_fifo_data;
`ifdef UART_PARITY_EN
    logic                 r_parity;
`endif

    assign w_push   = dout_vld && dout_rdy;
    assign dout_rdy = !w_fifo_full;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (dout_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign w_bit_end  = (r_div_cnt == DW'(BIT_CYCLES - 1));
    assign w_last_bit = (r_bit_cnt == 3'(DATA_BITS - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_dout_nxt  = 1'b1;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                w_dout_nxt = 1'b0;
                if (w_bit_end) w_state_nxt = DATA;
            end
            DATA: begin
                w_dout_nxt = r_shift[0];
                if (w_bit_end && w_last_bit) begin
`ifdef UART_PARITY_EN
                    w_state_nxt = PARITY;
`else
                    w_state_nxt = STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                w_dout_nxt = r_parity;
                if (w_bit_end) w_state_nxt = STOP;
            end
`endif
            STOP: begin
                // Chain straight into the next start bit when a byte is waiting.
                if (w_bit_end) begin
                    if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_dout    <= 1'b1;
`ifdef UART_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_dout <= w_dout_nxt;

            if (r_state == IDLE || w_bit_end) r_div_cnt <= '0;
            else                              r_div_cnt <= r_div_cnt + DW'(1);

            if (r_state == IDLE || r_state == START)
                r_bit_cnt <= '0;
            else if (r_state == DATA && w_bit_end)
                r_bit_cnt <= r_bit_cnt + 3'd1;

            if (w_pop) begin
                r_shift  <= w_fifo_data;
`ifdef UART_PARITY_EN
                r_parity <= even_parity(w_fifo_data);
`endif
            end else if (r_state == DATA && w_bit_end) begin
                r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
            end
        end
    end

    assign dout = r_dout;
    assign busy = (r_state != IDLE) || (w_fifo_count != '0);

endmodule

// File: tb/tb_uart_send.sv
// Directed bench for uart_send with a short bit period and a serial-line decoder model.
module tb_uart_send;

    localparam int unsigned BITC = 10;
`ifdef UART_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FRAME = NBITS * BITC;

    logic       clk = 1'b0;
    logic       rst;
    logic       dout_vld;
    logic [7:0] dout_data;
    logic       dout_rdy;
    logic       dout;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int busy_hi;
    int acc;

    logic [7:0] rx_q[$];
    logic       rx_stop_q[$];
    logic       rx_par_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] t3 [6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};

    uart_send #(
        .BIT_CYCLES (BITC),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dout_vld  (dout_vld),
        .dout_data (dout_data),
        .dout_rdy  (dout_rdy),
        .dout      (dout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // Serial receiver model: mid-bit sampling triggered by the start-bit edge.
    initial begin : rx_model
        logic [7:0] b;
        logic       s;
        forever begin
            @(negedge dout);
            repeat (BITC / 2) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BITC) @(posedge clk);
                #1 b[i] = dout;
            end
`ifdef UART_PARITY_EN
            repeat (BITC) @(posedge clk);
            #1 rx_par_q.push_back(dout);
`endif
            repeat (BITC) @(posedge clk);
            #1 s = dout;
            rx_q.push_back(b);
            rx_stop_q.push_back(s);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at the sample just after START was entered; returns at the sample
    // after the last stop-bit cycle.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic lvl;
        int   cnt;
        chk({tag, "_pre"}, {31'd0, dout}, 32'd1);
        for (int i = 0; i < int'(NBITS); i++) begin
            if (i == 0)                   lvl = 1'b0;
            else if (i <= 8)              lvl = b[i-1];
            else if (i == int'(NBITS)-1)  lvl = 1'b1;
            else                          lvl = ^b;
            cnt = 0;
            for (int c = 0; c < int'(BITC); c++) begin
                if (busy === 1'b1) busy_hi++;
                tick();
                if (dout === lvl) cnt++;
            end
            chk($sformatf("%s_bit%0d", tag, i), cnt, BITC);
        end
    endtask

    task automatic check_rx(input string tag);
        int bad_stop = 0;
        chk({tag, "_rx_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < int'(exp_q.size()); i++)
            if (i < int'(rx_q.size()))
                chk($sformatf("%s_rx%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        foreach (rx_stop_q[i]) if (rx_stop_q[i] !== 1'b1) bad_stop++;
        chk({tag, "_stop_bits"}, bad_stop, 0);
        rx_q.delete();
        rx_stop_q.delete();
        rx_par_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int n = 0;
        while (busy === 1'b1 && n < lim) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic step3();
        logic pre;
        dout_data = t3[(acc < 6) ? acc : 5];
        pre = dout_vld && dout_rdy;
        tick();
        if (pre) acc++;
    endtask

    initial begin : main
        int lows;
        int bhs;
        int to_cnt;
        int guard;
        logic pre;
        logic [7:0] b;

        rst = 1'b1;
        dout_vld = 1'b0;
        dout_data = 8'h00;
        repeat (3) tick();
        chk("rst_dout", {31'd0, dout}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdy", {31'd0, dout_rdy}, 32'd1);
        rst = 1'b0;
        repeat (5) tick();

        // 1: single byte from idle
        dout_vld = 1'b1; dout_data = 8'h55;
        tick();
        dout_vld = 1'b0;
        chk("t1_busy_on_push", {31'd0, busy}, 32'd1);
        chk("t1_dout_idle", {31'd0, dout}, 32'd1);
        tick();
        busy_hi = 0;
        check_frame(8'h55, "t1");
        chk("t1_busy_cycles", busy_hi, FRAME);
        chk("t1_busy_end", {31'd0, busy}, 32'd0);
        tick();
        chk("t1_idle_high", {31'd0, dout}, 32'd1);
        exp_q.push_back(8'h55);
        check_rx("t1");
        repeat (3) tick();

        // 2: three bytes back to back, no idle gap
        busy_hi = 0;
        fork
            begin
                dout_vld = 1'b1; dout_data = 8'hA3;
                tick();
                dout_data = 8'h00;
                tick();
                dout_data = 8'hFF;
                tick();
                dout_vld = 1'b0;
            end
        join_none
        tick();
        tick();
        check_frame(8'hA3, "t2a");
        check_frame(8'h00, "t2b");
        check_frame(8'hFF, "t2c");
        chk("t2_busy_cycles", busy_hi, 3 * FRAME);
        chk("t2_busy_end", {31'd0, busy}, 32'd0);
        exp_q.push_back(8'hA3); exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
        check_rx("t2");
        repeat (3) tick();

        // 3: valid held high, FIFO fills behind the byte in flight
        acc = 0;
        dout_vld = 1'b1;
        repeat (4) step3();
        chk("t3_rdy_three_queued", {31'd0, dout_rdy}, 32'd1);
        step3();
        chk("t3_rdy_full", {31'd0, dout_rdy}, 32'd0);
        chk("t3_accepted_full", acc, 5);
        repeat (FRAME - 4) step3();
        chk("t3_rdy_before_pop", {31'd0, dout_rdy}, 32'd0);
        step3();
        chk("t3_rdy_after_pop", {31'd0, dout_rdy}, 32'd1);
        chk("t3_accepted_at_pop", acc, 5);
        step3();
        chk("t3_rdy_refull", {31'd0, dout_rdy}, 32'd0);
        chk("t3_accepted_refill", acc, 6);
        dout_vld = 1'b0;
        wait_idle("t3", 8 * FRAME);
        foreach (t3[i]) exp_q.push_back(t3[i]);
        check_rx("t3");
        repeat (3) tick();

        // 4: reset during data bit 4 of 0x3C with two bytes queued
        dout_vld = 1'b1; dout_data = 8'h3C;
        tick();
        dout_data = 8'h11;
        tick();
        dout_data = 8'h22;
        tick();
        dout_vld = 1'b0;
        repeat (5 * BITC + 1) tick();
        chk("t4_in_bit4", {31'd0, dout}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_dout_after_rst", {31'd0, dout}, 32'd1);
        chk("t4_busy_after_rst", {31'd0, busy}, 32'd0);
        chk("t4_rdy_after_rst", {31'd0, dout_rdy}, 32'd1);
        lows = 0;
        bhs = 0;
        repeat (2 * FRAME) begin
            tick();
            if (dout !== 1'b1) lows++;
            if (busy !== 1'b0) bhs++;
        end
        chk("t4_no_more_frames", lows, 0);
        chk("t4_stays_idle", bhs, 0);
        rx_q.delete();
        rx_stop_q.delete();
        rx_par_q.delete();

        // 5: 256 random bytes through the receiver model
        to_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            dout_vld = 1'b1;
            dout_data = b;
            guard = 0;
            do begin
                pre = dout_rdy;
                tick();
                guard++;
            end while (!pre && guard < int'(4 * FRAME));
            if (!pre) to_cnt++;
        end
        dout_vld = 1'b0;
        chk("t5_push_timeouts", to_cnt, 0);
        wait_idle("t5", 6 * FRAME);
        check_rx("t5");
        repeat (3) tick();

        // 6: parity-sensitive bytes
        dout_vld = 1'b1; dout_data = 8'h07;
        tick();
        dout_vld = 1'b0;
        tick();
        busy_hi = 0;
        check_frame(8'h07, "t6a");
        chk("t6a_busy_cycles", busy_hi, FRAME);
        repeat (2) tick();
        dout_vld = 1'b1; dout_data = 8'h03;
        tick();
        dout_vld = 1'b0;
        tick();
        busy_hi = 0;
        check_frame(8'h03, "t6b");
        chk("t6b_busy_cycles", busy_hi, FRAME);
`ifdef UART_PARITY_EN
        chk("t6_par_count", rx_par_q.size(), 2);
        if (rx_par_q.size() == 2) begin
            chk("t6_par_07", {31'd0, rx_par_q[0]}, 32'd1);
            chk("t6_par_03", {31'd0, rx_par_q[1]}, 32'd0);
        end
`endif
        exp_q.push_back(8'h07); exp_q.push_back(8'h03);
        check_rx("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
